axis_pkt_rr_arb: RTL and testbench

AXIS_PKT_RR_ARB -- requirements
Module: axis_pkt_rr_arb

---
 rtl/axis_pkt_rr_arb_pkg.sv | 31 +++
 rtl/axis_pkt_rr_pick.sv | 20 ++
 rtl/axis_pkt_rr_arb.sv | 105 ++++++++++
 tb/tb_axis_pkt_rr_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_rr_arb_pkg.sv
// Shared FSM state type and round-robin priority function for axis_pkt_rr_arb.
package axis_pkt_rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  localparam int MAX_PORTS = 16;
  localparam int MAX_IDX_W = 4;

  // First requester strictly after 'last', wrapping modulo num_ports; returns 'last' if none.
  function automatic logic [MAX_IDX_W-1:0] rr_next(
    input logic [MAX_PORTS-1:0] req,
    input logic [MAX_IDX_W-1:0] last,
    input int                   num_ports
  );
    logic [MAX_IDX_W-1:0] idx;
    logic                 found;
    rr_next = last;
    found   = 1'b0;
    for (int i = 1; i <= MAX_PORTS; i++) begin
      idx = MAX_IDX_W'((int'(last) + i) % num_ports);
      if (i <= num_ports && !found && req[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axis_pkt_rr_pick.sv
// Combinational round-robin picker: request vector plus previous winner -> next winner and any-request flag.
module axis_rr_pick
  import axis_pkt_rr_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     grant,
  output logic                 any
);

  logic [MAX_IDX_W-1:0] pick;

  assign pick  = rr_next(MAX_PORTS'(req), MAX_IDX_W'(last), NUM_PORTS);
  assign grant = IDX_W'(pick);
  assign any   = |req;

endmodule

// File: rtl/axis_pkt_rr_arb.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream inputs; one idle arbitration cycle per packet.
// Optional per-port packet counters (output pkt_cnt) when AXIS_PKT_RR_ARB_STATS_EN is defined.
module axis_pkt_rr_arb
  import axis_pkt_rr_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int WORD_W    = 8,
  parameter  int WORDS     = 4,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int BEAT_W    = WORDS * WORD_W
) (
  input  logic                        clk,
  input  logic                        areset_n,
  input  logic [NUM_PORTS-1:0]        port_en,
  input  logic [NUM_PORTS*BEAT_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*WORDS-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]        s_axis_tlast,
  input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
  output logic [NUM_PORTS-1:0]        s_axis_tready,
  output logic [BEAT_W-1:0]           m_axis_tdata,
  output logic [WORDS-1:0]            m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [IDX_W-1:0]            m_axis_tdest,
  output logic                        busy
`ifdef AXIS_PKT_RR_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]     pkt_cnt
`endif
);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     grant, last_grant, pick;
  logic                 pick_vld;
  logic [NUM_PORTS-1:0] eligible;
  logic                 pkt_done;

  assign eligible     = s_axis_tvalid & port_en;
  assign m_axis_tdest = grant;

  axis_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (eligible),
    .last  (last_grant),
    .grant (pick),
    .any   (pick_vld)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Data path is always steered by grant; only the handshake signals depend on state.
  always_comb begin
    state_nxt     = state;
    s_axis_tready = '0;
    m_axis_tdata  = s_axis_tdata[int'(grant)*BEAT_W +: BEAT_W];
    m_axis_tkeep  = s_axis_tkeep[int'(grant)*WORDS +: WORDS];
    m_axis_tlast  = s_axis_tlast[grant];
    m_axis_tvalid = 1'b0;
    busy          = 1'b0;
    pkt_done      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = PASS;
      end
      PASS: begin
        busy                 = 1'b1;
        m_axis_tvalid        = s_axis_tvalid[grant];
        s_axis_tready[grant] = m_axis_tready;
        pkt_done             = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        if (pkt_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset value of last_grant makes port 0 the first winner.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      grant      <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
    end else begin
      if (state == IDLE && pick_vld) grant <= pick;
      if (pkt_done) last_grant <= grant;
    end
  end

`ifdef AXIS_PKT_RR_ARB_STATS_EN
  logic [31:0] cnt [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n)                          cnt[p] <= '0;
      else if (pkt_done && grant == IDX_W'(p)) cnt[p] <= cnt[p] + 32'd1;
    end
    assign pkt_cnt[p*32 +: 32] = cnt[p];
  end
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// Directed bench for axis_pkt_rr_arb: per-port packet sources, beat-exact output check, grant-order logs.
`timescale 1ns/1ps
module tb_axis_pkt_rr_arb;
  localparam int NP = 4;
  localparam int WW = 8;
  localparam int WD = 4;
  localparam int BW = WW * WD;

  logic            clk = 1'b0;
  logic            areset_n;
  logic [NP-1:0]   port_en;
  logic [NP*BW-1:0] s_axis_tdata;
  logic [NP*WD-1:0] s_axis_tkeep;
  logic [NP-1:0]   s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [BW-1:0]   m_axis_tdata;
  logic [WD-1:0]   m_axis_tkeep;
  logic            m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [1:0]      m_axis_tdest;
  logic            busy;
`ifdef AXIS_PKT_RR_ARB_STATS_EN
  logic [NP*32-1:0] pkt_cnt;
`endif

  always #5 clk = ~clk;

  axis_pkt_rr_arb #(.NUM_PORTS(NP), .WORD_W(WW), .WORDS(WD)) dut (
    .clk           (clk),
    .areset_n      (areset_n),
    .port_en       (port_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdest  (m_axis_tdest),
    .busy          (busy)
`ifdef AXIS_PKT_RR_ARB_STATS_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int pkts_left [NP];
  int fixed_len [NP];
  int beat      [NP];
  int seq       [NP];
  logic [NP-1:0] gate;
  logic [NP-1:0] rdy_seen;
  bit   var_len;
  int   out_beats;
  int   log_dest[$];
  int   log_cyc[$];
  int   log_len[$];

  function automatic logic [BW-1:0] exp_dat(int p, int b, int s);
    return {8'hA5, 8'(s), 8'(p), 8'(b)};
  endfunction

  // In variable-length mode packet k of a port carries k+1 words.
  function automatic int pkt_beats(int p);
    return var_len ? (seq[p] + 4) / 4 : fixed_len[p];
  endfunction

  function automatic logic [WD-1:0] last_keep(int p);
    int r;
    r = (seq[p] + 1) % WD;
    if (!var_len || r == 0) return 4'hF;
    return 4'((1 << r) - 1);
  endfunction

  function automatic bit all_done();
    int s;
    s = 0;
    for (int p = 0; p < NP; p++) s += pkts_left[p];
    return s == 0;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      logic lst;
      lst = (beat[p] == pkt_beats(p) - 1);
      s_axis_tvalid[p]          = (pkts_left[p] > 0) && gate[p];
      s_axis_tdata[p*BW +: BW]  = exp_dat(p, beat[p], seq[p]);
      s_axis_tkeep[p*WD +: WD]  = lst ? last_keep(p) : 4'hF;
      s_axis_tlast[p]           = lst;
    end
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) begin
      pkts_left[p] = 0; beat[p] = 0; seq[p] = 0; fixed_len[p] = 1;
    end
    gate = '1; var_len = 1'b0; out_beats = 0;
    log_dest.delete(); log_cyc.delete(); log_len.delete();
  endtask

  // One clock: check the output beat about to transfer, then advance the sources.
  task automatic tick();
    logic [NP-1:0]    hs;
    logic [BW+WD:0]   got, want;
    logic             lst;
    int               d;
    #1;
    hs = s_axis_tvalid & s_axis_tready;
    rdy_seen |= s_axis_tready;
    if (areset_n && m_axis_tvalid && m_axis_tready) begin
      d    = int'(m_axis_tdest);
      lst  = (beat[d] == pkt_beats(d) - 1);
      got  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      want = {exp_dat(d, beat[d], seq[d]), lst ? last_keep(d) : 4'hF, lst};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL beat port%0d cyc%0d: got %h want %h", d, cyc, got, want);
      end
      out_beats++;
      if (m_axis_tlast) begin
        log_dest.push_back(d); log_cyc.push_back(cyc); log_len.push_back(out_beats);
        out_beats = 0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        if (beat[p] == pkt_beats(p) - 1) begin
          beat[p] = 0; seq[p]++; pkts_left[p]--;
        end else begin
          beat[p]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic run_until(input int nlog, input int budget);
    int k;
    k = 0;
    while (log_dest.size() < nlog && k < budget) begin
      tick(); k++;
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0; port_en = '1; m_axis_tready = 1'b1; cyc = 0;
    clear_sources(); drive();
    #2;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (s_axis_tready !== 4'b0000) begin n_err++; $display("FAIL reset_tready: got %b want 0000", s_axis_tready); end
    n_cmp++; if (m_axis_tdest !== 2'd0) begin n_err++; $display("FAIL reset_tdest: got %0d want 0", m_axis_tdest); end
    tick(); tick();
    areset_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: got busy=%b tvalid=%b want 0/0", busy, m_axis_tvalid); end
    n_cmp++; if (m_axis_tdest !== 2'd0) begin n_err++; $display("FAIL idle_tdest: got %0d want 0", m_axis_tdest); end
  endtask

  task automatic test_rr_order();
    int  exp_d [5] = '{0, 1, 2, 3, 0};
    int  exp_c [5] = '{3, 7, 11, 15, 19};
    bit  bubble_checked;
    clear_sources();
    for (int p = 0; p < NP; p++) begin pkts_left[p] = 2; fixed_len[p] = 3; end
    drive(); cyc = 0; bubble_checked = 1'b0;
    for (int k = 0; k < 60 && log_dest.size() < 8; k++) begin
      tick();
      if (log_dest.size() == 1 && !bubble_checked) begin
        bubble_checked = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000) begin
          n_err++; $display("FAIL rr_bubble: got busy=%b tvalid=%b tready=%b want 0/0/0000", busy, m_axis_tvalid, s_axis_tready);
        end
      end
    end
    n_cmp++;
    if (log_dest.size() !== 8) begin n_err++; $display("FAIL rr_count: got %0d packets want 8", log_dest.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (log_dest[i] !== exp_d[i] || log_cyc[i] !== exp_c[i]) begin
          n_err++; $display("FAIL rr_order[%0d]: got port%0d@%0d want port%0d@%0d", i, log_dest[i], log_cyc[i], exp_d[i], exp_c[i]);
        end
      end
    end
  endtask

  // Single-beat packets on ports 1 and 3 only; disabled ports must never see tready.
  task automatic test_port_en();
    int exp_d [4] = '{1, 3, 1, 3};
    clear_sources();
    for (int p = 0; p < NP; p++) begin pkts_left[p] = 2; fixed_len[p] = 1; end
    port_en = 4'b1010; rdy_seen = '0;
    drive(); cyc = 0;
    run_until(4, 40);
    n_cmp++;
    if (log_dest.size() !== 4) begin n_err++; $display("FAIL en_count: got %0d packets want 4", log_dest.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log_dest[i] !== exp_d[i]) begin n_err++; $display("FAIL en_order[%0d]: got %0d want %0d", i, log_dest[i], exp_d[i]); end
      end
      n_cmp++;
      if (log_cyc[3] - log_cyc[0] !== 6) begin n_err++; $display("FAIL single_beat_spacing: got %0d want 6", log_cyc[3] - log_cyc[0]); end
    end
    n_cmp++;
    if (rdy_seen[0] !== 1'b0 || rdy_seen[2] !== 1'b0) begin n_err++; $display("FAIL en_tready02: got %b want 0x0x", rdy_seen); end
    pkts_left[0] = 0; pkts_left[2] = 0; port_en = '1;
    drive(); tick();
  endtask

  task automatic test_stall();
    bit stalled, early0;
    clear_sources();
    fixed_len[2] = 10; fixed_len[0] = 2;
    pkts_left[2] = 1;  pkts_left[0] = 1;
    gate = 4'b0100; stalled = 1'b0; early0 = 1'b0;
    drive(); cyc = 0;
    for (int k = 0; k < 300 && log_dest.size() < 2; k++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      if (beat[2] >= 3 && !gate[0]) begin gate[0] = 1'b1; drive(); end
      if (beat[2] == 5 && !stalled) begin
        stalled = 1'b1; gate[2] = 1'b0; drive();
        repeat (2) begin
          tick();
          n_cmp++;
          if (m_axis_tvalid !== 1'b0 || busy !== 1'b1 || m_axis_tdest !== 2'd2) begin
            n_err++; $display("FAIL stall_hold: got tvalid=%b busy=%b tdest=%0d want 0/1/2", m_axis_tvalid, busy, m_axis_tdest);
          end
        end
        gate[2] = 1'b1; drive();
      end
      tick();
      if (log_dest.size() == 0 && s_axis_tready[0]) early0 = 1'b1;
    end
    m_axis_tready = 1'b1;
    n_cmp++;
    if (log_dest.size() !== 2) begin n_err++; $display("FAIL stall_count: got %0d packets want 2", log_dest.size()); end
    else begin
      n_cmp++;
      if (log_dest[0] !== 2 || log_dest[1] !== 0 || log_len[0] !== 10) begin
        n_err++; $display("FAIL stall_order: got %0d(%0d beats),%0d want 2(10 beats),0", log_dest[0], log_len[0], log_dest[1]);
      end
      n_cmp++;
      if (log_cyc[1] - log_cyc[0] < 3) begin n_err++; $display("FAIL stall_gap: got %0d want >=3", log_cyc[1] - log_cyc[0]); end
    end
    n_cmp++;
    if (early0 !== 1'b0) begin n_err++; $display("FAIL stall_early_port0: got 1 want 0"); end
  endtask

  task automatic test_en_clear();
    int exp_d [4] = '{1, 2, 2, 1};
    clear_sources();
    fixed_len[1] = 5; fixed_len[2] = 5;
    pkts_left[1] = 2; pkts_left[2] = 2;
    port_en = '1;
    drive(); cyc = 0;
    for (int k = 0; k < 100 && log_dest.size() < 3; k++) begin
      if (beat[1] == 2 && log_dest.size() == 0) port_en[1] = 1'b0;
      tick();
    end
    port_en = '1;
    run_until(4, 40);
    n_cmp++;
    if (log_dest.size() !== 4) begin n_err++; $display("FAIL enclr_count: got %0d packets want 4", log_dest.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log_dest[i] !== exp_d[i]) begin n_err++; $display("FAIL enclr_order[%0d]: got %0d want %0d", i, log_dest[i], exp_d[i]); end
      end
      n_cmp++;
      if (log_len[0] !== 5) begin n_err++; $display("FAIL enclr_len: got %0d beats want 5", log_len[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int exp_d [3] = '{0, 1, 3};
    clear_sources();
    fixed_len[1] = 6; fixed_len[0] = 2; fixed_len[3] = 2;
    pkts_left[1] = 1; pkts_left[0] = 1; pkts_left[3] = 1;
    gate = 4'b0010; port_en = '1;
    drive(); cyc = 0;
    for (int k = 0; k < 20 && beat[1] < 2; k++) tick();
    gate = 4'b1011; drive();
    tick();
    #2;
    areset_n = 1'b0;
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 4'b0000 || m_axis_tdest !== 2'd0) begin
      n_err++; $display("FAIL rst_mid_outputs: got tvalid=%b busy=%b tready=%b tdest=%0d want 0/0/0000/0", m_axis_tvalid, busy, s_axis_tready, m_axis_tdest);
    end
    beat[1] = 0; out_beats = 0; drive();
    tick(); tick();
    areset_n = 1'b1;
    log_dest.delete(); log_cyc.delete(); log_len.delete();
    run_until(3, 60);
    n_cmp++;
    if (log_dest.size() !== 3) begin n_err++; $display("FAIL rst_mid_count: got %0d packets want 3", log_dest.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (log_dest[i] !== exp_d[i]) begin n_err++; $display("FAIL rst_mid_order[%0d]: got %0d want %0d", i, log_dest[i], exp_d[i]); end
      end
      n_cmp++;
      if (log_len[1] !== 6) begin n_err++; $display("FAIL rst_mid_len: got %0d beats want 6", log_len[1]); end
    end
  endtask

`ifdef AXIS_PKT_RR_ARB_STATS_EN
  task automatic test_stats();
    int k;
    areset_n = 1'b0;
    clear_sources(); drive();
    tick(); tick();
    areset_n = 1'b1;
    tick();
    for (int p = 0; p < NP; p++) pkts_left[p] = 100;
    var_len = 1'b1; port_en = '1;
    drive(); cyc = 0; k = 0;
    while (!all_done() && k < 30000) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      tick(); k++;
    end
    m_axis_tready = 1'b1;
    tick();
    n_cmp++;
    if (log_dest.size() !== 400) begin n_err++; $display("FAIL stats_packets: got %0d want 400", log_dest.size()); end
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (pkt_cnt[p*32 +: 32] !== 32'd100) begin n_err++; $display("FAIL pkt_cnt[%0d]: got %0d want 100", p, pkt_cnt[p*32 +: 32]); end
    end
  endtask
`endif

  initial begin
    areset_n = 1'b0; port_en = '0; m_axis_tready = 1'b0; rdy_seen = '0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0; s_axis_tvalid = '0;
    test_reset();
    test_rr_order();
    test_port_en();
    test_stall();
    test_en_clear();
    test_reset_mid();
`ifdef AXIS_PKT_RR_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
